latq_wr_seq: RTL
================

LATQ_WR_SEQ -- requirements
Module: latq_wr_seq

Interface
REQ-001 SHALL have parameter W, default 8: data width, range 1..32.
REQ-002 SHALL have parameter SETUP_CYC, default 1: CLK cycles D is stable before E rises, range 1..15.
REQ-003 SHALL have parameter WIDTH_CYC, default 2: CLK cycles E is high, range 1..15.
REQ-004 SHALL have parameter HOLD_CYC, default 1: CLK cycles D is stable after E falls, range 1..15.
REQ-005 SHALL have port CLK, input, 1 bit: the only clock, rising-edge active.
REQ-006 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port REQ_VALID, input, 1 bit: the write request is valid.
REQ-008 SHALL have port REQ_D, input, W bits: the write data.
REQ-009 SHALL have port REQ_READY, output, 1 bit: the sequencer can accept a request.
REQ-010 SHALL have port D, output, W bits: data to the latch array.
REQ-011 SHALL have port E, output, 1 bit: latch enable, high-transparent.
REQ-012 SHALL have port BUSY, output, 1 bit: a sequence is in progress.
REQ-013 SHALL have port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-014 SHALL implement the FSM states IDLE, SETUP, PULSE and HOLD, with a 4-bit down-counter CNT.
REQ-015 SHALL drive D, E, BUSY and DONE directly from flops, with no combinational path from any input to them.
REQ-016 SHALL drive REQ_READY high only when the state is IDLE and RST=0.
REQ-017 SHALL treat a request as accepted on any rising edge where REQ_VALID=1 and REQ_READY=1; on that edge it SHALL load D<=REQ_D, enter SETUP, set CNT<=SETUP_CYC-1, and set BUSY<=1.
REQ-018 SETUP SHALL, when CNT=0, enter PULSE with E<=1 and CNT<=WIDTH_CYC-1; otherwise it SHALL decrement CNT.
REQ-019 PULSE SHALL, when CNT=0, enter HOLD with E<=0 and CNT<=HOLD_CYC-1; otherwise it SHALL decrement CNT.
REQ-020 HOLD SHALL, when CNT=0, enter IDLE with DONE<=1 and BUSY<=0; otherwise it SHALL decrement CNT.
REQ-021 Timing from the accept edge t SHALL be: E rises at edge t+SETUP_CYC, E falls at edge t+SETUP_CYC+WIDTH_CYC, DONE is high for exactly the one cycle following edge t+SETUP_CYC+WIDTH_CYC+HOLD_CYC.
REQ-022 D SHALL change only on an accept edge or a reset edge, so D is constant from the accept edge through the end of HOLD.
REQ-023 In IDLE, D SHALL keep its last written value and E SHALL be 0.
REQ-024 A new request SHALL be acceptable in the same cycle DONE is high (back-to-back operation), so the minimum period is SETUP_CYC+WIDTH_CYC+HOLD_CYC+1 cycles.
REQ-025 REQ_VALID and REQ_D SHALL be ignored outside IDLE; a request held through BUSY SHALL be accepted on the first IDLE cycle.
REQ-026 E SHALL never be high while the state is IDLE, SETUP or HOLD.
REQ-027 E SHALL be high for exactly WIDTH_CYC consecutive cycles per accepted request, with no glitch.
REQ-028 Parameter values of 0 SHALL be rejected at elaboration.

Reset
REQ-029 While RST=1 at a rising edge, the block SHALL set state=IDLE, CNT=0, D=0, E=0, BUSY=0 and DONE=0, and SHALL hold REQ_READY=0.
REQ-030 Reset asserted mid-sequence SHALL take priority: E falls at that same edge, and no DONE is produced for the aborted request.
REQ-031 On the first edge with RST=0, the block SHALL be in IDLE with REQ_READY=1.

Verification
REQ-032 A bench SHALL check, with default parameters: reset, then REQ_D=8'hA5 accepted at edge 0 -> D=8'hA5 after edge 0, E=1 after edges 1..2, E=0 after edge 3, DONE=1 only after edge 4, BUSY=1 after edges 0..3.
REQ-033 A bench SHALL check back-to-back requests 8'h3C then 8'hC3 with REQ_VALID held high -> the second is accepted in the DONE cycle, and the E pulses are separated by exactly 3 low cycles.
REQ-034 A bench SHALL check that changing REQ_D while BUSY -> D stays at the accepted value until the next accept.
REQ-035 A bench SHALL check RST asserted during PULSE -> E=0, D=0 and BUSY=0 at that edge, no DONE, and REQ_READY=1 one edge after release.
REQ-036 A bench SHALL check SETUP_CYC=3, WIDTH_CYC=1, HOLD_CYC=4 -> E high only after edge 3, DONE only after edge 8.
REQ-037 A bench SHALL check, as a random-stimulus assertion, that D never changes while E=1 or during the HOLD_CYC cycles after E falls.

Source files
------------

// File: rtl/latq_wr_seq.sv
// Write-pulse sequencer for a latch array: presents D, then pulses the
// high-transparent enable E with programmable setup, width and hold in CLK cycles.
module latq_wr_seq #(
    parameter int unsigned W         = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned WIDTH_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ_VALID,
    input  logic [W-1:0] REQ_D,
    output logic         REQ_READY,
    output logic [W-1:0] D,
    output logic         E,
    output logic         BUSY,
    output logic         DONE
);

    generate
        if (W == 0 || W > 32) begin : g_bad_w
            $error("latq_wr_seq: W must be in 1..32");
        end
        if (SETUP_CYC == 0 || SETUP_CYC > 15) begin : g_bad_setup
            $error("latq_wr_seq: SETUP_CYC must be in 1..15");
        end
        if (WIDTH_CYC == 0 || WIDTH_CYC > 15) begin : g_bad_width
            $error("latq_wr_seq: WIDTH_CYC must be in 1..15");
        end
        if (HOLD_CYC == 0 || HOLD_CYC > 15) begin : g_bad_hold
            $error("latq_wr_seq: HOLD_CYC must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
    localparam logic [3:0] WIDTH_LD = 4'(WIDTH_CYC - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD
    } state_t;

    state_t       r_state, w_state_nxt;
    logic [3:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0] r_d, w_d_nxt;
    logic         r_e, w_e_nxt;
    logic         r_busy, w_busy_nxt;
    logic         r_done, w_done_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_d     <= '0;
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_d     <= w_d_nxt;
            r_e     <= w_e_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // DONE is a pulse, so it defaults low; IDLE accepts even while DONE is up.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_d_nxt     = r_d;
        w_e_nxt     = r_e;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (REQ_VALID) begin
                    w_state_nxt = SETUP;
                    w_cnt_nxt   = SETUP_LD;
                    w_d_nxt     = REQ_D;
                    w_busy_nxt  = 1'b1;
                end
            end
            SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = PULSE;
                    w_cnt_nxt   = WIDTH_LD;
                    w_e_nxt     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            PULSE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = HOLD_LD;
                    w_e_nxt     = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = IDLE;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_e_nxt     = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign REQ_READY = (r_state == IDLE) && !RST;
    assign D         = r_d;
    assign E         = r_e;
    assign BUSY      = r_busy;
    assign DONE      = r_done;

endmodule
